inst_fetch: RTL and testbench

Instruction fetch stage of the RV32I core, directly upstream of the instruction decoder. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake with one outstanding transaction. It buffers returned words with their PCs in a small FIFO and presents them to the decoder with a valid qualifier that drives the decoder's `clkEn`. It honours the decoder's `stall` and the execute stage's taken-branch/jump redirect.

---
 rtl/inst_fetch_if.sv | 9 +
 rtl/inst_fetch.sv | 56 +++++
 tb/tb_inst_fetch.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction memory read handshake, one outstanding transaction.
interface inst_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, addr, input ack, rdata);
  modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: RV32I fetch stage; issues word reads and queues {pc, instr} for the decoder.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rstB,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  inst_fetch_if.master imem,
  output logic [31:0]  instruction_out,
  output logic [31:0]  pc_out,
  output logic         inst_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, DROP = 2'd2;
  logic [1:0]    state;
  logic [31:0]   fpc, drop_addr;
  logic [AW:0]   count;
  logic [AW-1:0] wp, rp;
  logic [31:0]   mem_i [DEPTH];
  logic [31:0]   mem_p [DEPTH];
  logic          ack, push, pop;
  // a request only starts with a free slot; count can only fall until its ack, so req stays stable
  assign imem.req        = state == DROP || (state == FETCH && count < FULL);
  assign imem.addr       = state == DROP ? drop_addr : fpc;
  assign ack             = imem.req && imem.ack;
  assign push            = ack && state == FETCH && !redirect;
  assign pop             = inst_valid && !stall && !redirect;
  assign inst_valid      = count != '0;
  assign instruction_out = inst_valid ? mem_i[rp] : '0;
  assign pc_out          = inst_valid ? mem_p[rp] : '0;
  always_ff @(posedge clk or negedge rstB)
    if (!rstB) begin
      state     <= IDLE;
      fpc       <= RESET_PC;
      drop_addr <= RESET_PC;
      count     <= '0;
      wp        <= '0;
      rp        <= '0;
    end else begin
      state     <= redirect && imem.req && !imem.ack ? DROP : state == IDLE || ack ? FETCH : state;
      fpc       <= redirect ? redirect_pc & ~32'h3 : push ? fpc + 32'd4 : fpc;
      drop_addr <= redirect ? imem.addr : drop_addr;
      count     <= redirect ? '0 : push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
      wp        <= redirect ? '0 : push ? wp + 1'b1 : wp;
      rp        <= redirect ? '0 : pop ? rp + 1'b1 : rp;
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_i[wp] <= imem.rdata;
      mem_p[wp] <= fpc;
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a program-order stream model.
module tb_inst_fetch;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic        clk = 0, rstB = 1, stall = 0, redirect = 0;
  logic [31:0] redirect_pc = 0, instruction_out, pc_out;
  logic        inst_valid;
  int          n_cmp = 0, n_fail = 0, lat = 0, wcnt = 0;

  inst_fetch_if imem();

  inst_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rstB(rstB), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem(imem), .instruction_out(instruction_out), .pc_out(pc_out), .inst_valid(inst_valid)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // memory responder: acks after lat wait cycles, returns addr ^ K, garbage ack while idle
  task automatic cyc();
    @(negedge clk);
    if (imem.req) begin
      if (wcnt >= lat) begin imem.ack = 1; imem.rdata = imem.addr ^ K; wcnt = 0; end
      else begin imem.ack = 0; imem.rdata = $urandom; wcnt++; end
    end else begin
      imem.ack = 1'($urandom_range(0, 1)); imem.rdata = $urandom; wcnt = 0;
    end
  endtask

  task automatic do_reset(input int l);
    rstB = 0; stall = 0; redirect = 0; lat = l; wcnt = 0; imem.ack = 0;
    repeat (2) @(negedge clk);
    rstB = 1;
  endtask

  task automatic test_reset();
    #2 rstB = 0;
    #1;
    n_cmp++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, expected 0", imem.req); end
    n_cmp++; if (imem.addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h, expected 0", imem.addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", inst_valid); end
    n_cmp++; if (instruction_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h, expected 0", instruction_out); end
    n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h, expected 0", pc_out); end
    do_reset(0);
    n_cmp++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b, expected 0", imem.req); end
    cyc();
    n_cmp++; if ({imem.req, imem.addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL first_req: got %b/%h, expected 1/0", imem.req, imem.addr); end
  endtask

  task automatic test_stream();
    do_reset(0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      e = 32'(4 * i);
      cyc();
      n_cmp++; if ({inst_valid, pc_out} !== {1'b1, e}) begin n_fail++; $display("FAIL stream_pc: got %b/%h, expected 1/%h", inst_valid, pc_out, e); end
      n_cmp++; if (instruction_out !== (e ^ K)) begin n_fail++; $display("FAIL stream_instr: got %h, expected %h", instruction_out, e ^ K); end
    end
  endtask

  task automatic test_stall();
    int n;
    do_reset(0);
    n = 0;
    while (pc_out !== 32'h8 && n < 20) begin cyc(); n++; end
    n_cmp++; if (pc_out !== 32'h8) begin n_fail++; $display("FAIL stall_reach: got %h, expected 8", pc_out); end
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if ({inst_valid, pc_out, instruction_out} !== {1'b1, 32'h8, 32'h8 ^ K}) begin n_fail++; $display("FAIL stall_hold: got %b/%h/%h, expected 1/8/%h", inst_valid, pc_out, instruction_out, 32'h8 ^ K); end
      if (k > 0) begin
        n_cmp++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL stall_full_req: got %b, expected 0", imem.req); end
      end
      if (k < 2) cyc();
    end
    stall = 0;
    for (int j = 1; j <= 6; j++) begin
      logic [31:0] e;
      e = 32'(8 + 4 * j);
      cyc();
      n_cmp++; if ({inst_valid, pc_out, instruction_out} !== {1'b1, e, e ^ K}) begin n_fail++; $display("FAIL stall_release: got %b/%h/%h, expected 1/%h/%h", inst_valid, pc_out, instruction_out, e, e ^ K); end
    end
  endtask

  task automatic test_redirect_pending();
    int n;
    do_reset(3);
    n = 0;
    while (!(imem.req && imem.addr == 32'h10) && n < 100) begin cyc(); n++; end
    n_cmp++; if ({imem.req, imem.addr} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL rdp_reach: got %b/%h, expected 1/10", imem.req, imem.addr); end
    cyc();
    redirect = 1; redirect_pc = 32'h100;
    n = 0;
    do begin
      cyc();
      redirect = 0;
      n_cmp++; if ({imem.req, imem.addr} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL rdp_hold_addr: got %b/%h, expected 1/10", imem.req, imem.addr); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rdp_flush: got %b, expected 0", inst_valid); end
      n++;
    end while (!imem.ack && n < 10);
    n_cmp++; if (imem.ack !== 1'b1) begin n_fail++; $display("FAIL rdp_ack_timeout: got %b, expected 1", imem.ack); end
    cyc();
    n_cmp++; if ({imem.req, imem.addr, inst_valid} !== {1'b1, 32'h100, 1'b0}) begin n_fail++; $display("FAIL rdp_target_req: got %b/%h/%b, expected 1/100/0", imem.req, imem.addr, inst_valid); end
    n = 0;
    while (!inst_valid && n < 20) begin cyc(); n++; end
    n_cmp++; if ({inst_valid, pc_out, instruction_out} !== {1'b1, 32'h100, 32'h100 ^ K}) begin n_fail++; $display("FAIL rdp_first: got %b/%h/%h, expected 1/100/%h", inst_valid, pc_out, instruction_out, 32'h100 ^ K); end
  endtask

  task automatic test_redirect_on_ack();
    int n;
    do_reset(1);
    n = 0;
    while (!(imem.req && imem.addr == 32'h20 && imem.ack) && n < 100) begin cyc(); n++; end
    n_cmp++; if ({imem.ack, imem.addr} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL roa_reach: got %b/%h, expected 1/20", imem.ack, imem.addr); end
    redirect = 1; redirect_pc = 32'h200;
    cyc();
    redirect = 0;
    n_cmp++; if ({imem.req, imem.addr, inst_valid} !== {1'b1, 32'h200, 1'b0}) begin n_fail++; $display("FAIL roa_target_req: got %b/%h/%b, expected 1/200/0", imem.req, imem.addr, inst_valid); end
    n = 0;
    while (!inst_valid && n < 10) begin cyc(); n++; end
    n_cmp++; if ({inst_valid, pc_out} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL roa_first: got %b/%h, expected 1/200", inst_valid, pc_out); end
  endtask

  task automatic test_wrap();
    do_reset(0);
    cyc(); cyc();
    redirect = 1; redirect_pc = 32'hFFFF_FFF3;
    cyc();
    redirect = 0;
    n_cmp++; if ({imem.req, imem.addr, inst_valid} !== {1'b1, 32'hFFFF_FFF0, 1'b0}) begin n_fail++; $display("FAIL wrap_req: got %b/%h/%b, expected 1/fffffff0/0", imem.req, imem.addr, inst_valid); end
    for (int j = 0; j < 6; j++) begin
      logic [31:0] e;
      e = 32'hFFFF_FFF0 + 32'(4 * j);
      cyc();
      n_cmp++; if ({inst_valid, pc_out, instruction_out} !== {1'b1, e, e ^ K}) begin n_fail++; $display("FAIL wrap_seq: got %b/%h/%h, expected 1/%h/%h", inst_valid, pc_out, instruction_out, e, e ^ K); end
    end
  endtask

  task automatic test_reset_midwait();
    int n;
    do_reset(5);
    stall = 1;
    n = 0;
    while (!(inst_valid && imem.req && !imem.ack) && n < 40) begin cyc(); n++; end
    n_cmp++; if ({inst_valid, imem.req} !== 2'b11) begin n_fail++; $display("FAIL rmw_reach: got %b/%b, expected 1/1", inst_valid, imem.req); end
    #1 rstB = 0;
    #1;
    n_cmp++; if ({imem.req, imem.addr} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL rmw_req: got %b/%h, expected 0/0", imem.req, imem.addr); end
    n_cmp++; if ({inst_valid, pc_out, instruction_out} !== 65'h0) begin n_fail++; $display("FAIL rmw_outputs: got %b/%h/%h, expected 0/0/0", inst_valid, pc_out, instruction_out); end
    do_reset(0);
    cyc();
    n_cmp++; if ({imem.req, imem.addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL rmw_restart_req: got %b/%h, expected 1/0", imem.req, imem.addr); end
    cyc();
    n_cmp++; if ({inst_valid, pc_out, instruction_out} !== {1'b1, 32'h0, K}) begin n_fail++; $display("FAIL rmw_restart_first: got %b/%h/%h, expected 1/0/%h", inst_valid, pc_out, instruction_out, K); end
  endtask

  // the decoder must see a gap-free program-order stream that restarts at each redirect target
  task automatic test_random();
    logic [31:0] exp_pc, prev_addr;
    logic        prev_req, prev_ack;
    int          consumed;
    do_reset(0);
    exp_pc = 32'h0; prev_req = 0; prev_ack = 0; prev_addr = 0; consumed = 0;
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) lat = $urandom_range(0, 3);
      cyc();
      if (inst_valid) begin
        n_cmp++; if (pc_out !== exp_pc) begin n_fail++; $display("FAIL rand_pc: got %h, expected %h", pc_out, exp_pc); end
        n_cmp++; if (instruction_out !== (exp_pc ^ K)) begin n_fail++; $display("FAIL rand_instr: got %h, expected %h", instruction_out, exp_pc ^ K); end
      end else begin
        n_cmp++; if ({pc_out, instruction_out} !== 64'h0) begin n_fail++; $display("FAIL rand_idle_out: got %h/%h, expected 0/0", pc_out, instruction_out); end
      end
      if (prev_req && !prev_ack) begin
        n_cmp++; if ({imem.req, imem.addr} !== {1'b1, prev_addr}) begin n_fail++; $display("FAIL rand_req_stable: got %b/%h, expected 1/%h", imem.req, imem.addr, prev_addr); end
      end
      prev_req = imem.req; prev_ack = imem.ack; prev_addr = imem.addr;
      stall = $urandom_range(0, 3) == 0;
      redirect = $urandom_range(0, 19) == 0;
      redirect_pc = $urandom;
      if (redirect) exp_pc = redirect_pc & ~32'h3;
      else if (inst_valid && !stall) begin exp_pc += 4; consumed++; end
    end
    redirect = 0; stall = 0;
    n_cmp++; if (consumed < 100) begin n_fail++; $display("FAIL rand_progress: got %0d, expected >= 100", consumed); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_pending();
    test_redirect_on_ack();
    test_wrap();
    test_reset_midwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
